// File: rtl/atm_transaction.sv
// ---------------------------------------------------------------------------
// atm_transaction
//
// Session controller for one ATM card. It walks a card through password
// authentication, a menu of balance operations and ejection, and produces a
// single-cycle write-back strobe with the new balance for each operation.
//
// Parameters
//   balance_width  : width of balance / amount / updated_balance
//   max_attempts   : wrong-password tries before the card is locked
//   timeout_cycles : MENU idle limit in clocks
//
// Ports
//   clk             : clock, all state on rising edge
//   rst             : asynchronous active-low reset
//   card_in         : card present
//   psw_valid       : password entered this cycle
//   wrong_psw       : password check result, valid the cycle after psw_valid
//   balance         : current account balance from card handling
//   op_valid        : operation request strobe (honoured only in MENU)
//   op_code         : 00 inquiry, 01 deposit, 10 withdraw, 11 exit
//   amount          : operation amount
//   updated_balance : balance to write back
//   op_done         : one-cycle write-back strobe
//   busy            : high in every state except IDLE
//   insufficient    : withdraw rejected (DONE cycle only)
//   overflow_err    : deposit rejected (DONE cycle only)
//   timeout         : MENU idle timeout pulse
//   card_locked     : attempt-limit pulse
//   card_eject      : eject pulse
// ---------------------------------------------------------------------------
module atm_transaction #(
  parameter int balance_width  = 20,
  parameter int max_attempts   = 3,
  parameter int timeout_cycles = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     psw_valid,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic [balance_width-1:0] updated_balance,
  output logic                     op_done,
  output logic                     busy,
  output logic                     insufficient,
  output logic                     overflow_err,
  output logic                     timeout,
  output logic                     card_locked,
  output logic                     card_eject
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] AUTH  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] MENU  = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] EJECT = 3'd6;

  localparam logic [1:0] OP_INQ  = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_WD   = 2'b10;

  localparam int ATT_W  = $clog2(max_attempts + 1);
  localparam int IDLE_W = $clog2(timeout_cycles + 1);

  localparam logic [ATT_W-1:0]  ATT_LIMIT = ATT_W'(max_attempts);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(timeout_cycles - 1);

  logic [2:0]              state;
  logic [ATT_W-1:0]        attempts;
  logic [IDLE_W-1:0]       idle_cnt;
  // Set on every eject; a card still sitting in the slot is not re-accepted
  // until card_in has been seen low, so one insertion yields one eject.
  logic                    wait_removal;

  logic [1:0]               op_code_p0;
  logic [balance_width-1:0] amount_p0;
  logic [balance_width:0]   dep_p1;
  logic [balance_width:0]   wd_p1;

  // Sum with the carry kept in the extra MSB.
  function automatic logic [balance_width:0] add_carry(
    input logic [balance_width-1:0] a,
    input logic [balance_width-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Difference with the borrow kept in the extra MSB (set when b > a).
  function automatic logic [balance_width:0] sub_borrow(
    input logic [balance_width-1:0] a,
    input logic [balance_width-1:0] b
  );
    return {1'b0, a} - {1'b0, b};
  endfunction

  assign busy = (state != IDLE);

  // ---- stage p0: operation capture in MENU --------------------------------
  always_ff @(posedge clk) begin
    if (state == MENU && op_valid) begin
      op_code_p0 <= op_code;
      amount_p0  <= amount;
    end
  end

  // ---- stage p1: EXEC arithmetic against the live balance -----------------
  always_comb begin
    dep_p1 = add_carry(balance, amount_p0);
    wd_p1  = sub_borrow(balance, amount_p0);
  end

  // ---- stage p2: control FSM and registered outputs (DONE cycle) ----------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      attempts        <= '0;
      idle_cnt        <= '0;
      wait_removal    <= 1'b0;
      updated_balance <= '0;
      op_done         <= 1'b0;
      insufficient    <= 1'b0;
      overflow_err    <= 1'b0;
      timeout         <= 1'b0;
      card_locked     <= 1'b0;
      card_eject      <= 1'b0;
    end else begin
      op_done      <= 1'b0;
      insufficient <= 1'b0;
      overflow_err <= 1'b0;
      timeout      <= 1'b0;
      card_locked  <= 1'b0;
      card_eject   <= 1'b0;

      if (state != IDLE && !card_in) begin
        // Card pulled: drop the session, leave the last committed balance.
        // op_done of a DONE cycle is already on the output and completes.
        state    <= IDLE;
        idle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            updated_balance <= balance;
            if (!card_in) begin
              wait_removal <= 1'b0;
            end else if (!wait_removal) begin
              state    <= AUTH;
              attempts <= '0;
            end
          end

          AUTH: begin
            if (psw_valid) state <= CHECK;
          end

          CHECK: begin
            if (!wrong_psw) begin
              attempts <= '0;
              idle_cnt <= '0;
              state    <= MENU;
            end else if (attempts + 1'b1 == ATT_LIMIT) begin
              attempts     <= attempts + 1'b1;
              state        <= EJECT;
              card_locked  <= 1'b1;
              card_eject   <= 1'b1;
              wait_removal <= 1'b1;
            end else begin
              attempts <= attempts + 1'b1;
              state    <= AUTH;
            end
          end

          MENU: begin
            if (op_valid) begin
              idle_cnt <= '0;
              state    <= EXEC;
            end else if (idle_cnt == IDLE_LAST) begin
              idle_cnt     <= '0;
              state        <= EJECT;
              timeout      <= 1'b1;
              card_eject   <= 1'b1;
              wait_removal <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end

          EXEC: begin
            case (op_code_p0)
              OP_INQ: begin
                updated_balance <= balance;
                op_done         <= 1'b1;
                state           <= DONE;
              end
              OP_DEP: begin
                op_done <= 1'b1;
                state   <= DONE;
                if (dep_p1[balance_width]) begin
                  updated_balance <= balance;
                  overflow_err    <= 1'b1;
                end else begin
                  updated_balance <= dep_p1[balance_width-1:0];
                end
              end
              OP_WD: begin
                op_done <= 1'b1;
                state   <= DONE;
                if (wd_p1[balance_width]) begin
                  updated_balance <= balance;
                  insufficient    <= 1'b1;
                end else begin
                  updated_balance <= wd_p1[balance_width-1:0];
                end
              end
              default: begin
                state        <= EJECT;
                card_eject   <= 1'b1;
                wait_removal <= 1'b1;
              end
            endcase
          end

          DONE: begin
            idle_cnt <= '0;
            state    <= MENU;
          end

          EJECT: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_transaction.sv
// ---------------------------------------------------------------------------
// tb_atm_transaction
//
// Scoreboard bench: every operation issued pushes its expected write-back
// (cycle, balance, flags) computed from plain account arithmetic; a monitor
// pops and compares whenever op_done is seen. Session-level events (lock,
// timeout, abort, reset) are checked directly by the driver.
// ---------------------------------------------------------------------------
module tb_atm_transaction;

  localparam int BW = 20;
  localparam logic [BW-1:0] BAL_MAX = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          card_in = 1'b0;
  logic          psw_valid = 1'b0;
  logic          wrong_psw = 1'b0;
  logic [BW-1:0] balance = '0;
  logic          op_valid = 1'b0;
  logic [1:0]    op_code = 2'b00;
  logic [BW-1:0] amount = '0;
  logic [BW-1:0] updated_balance;
  logic          op_done, busy, insufficient, overflow_err;
  logic          timeout, card_locked, card_eject;

  typedef struct {
    int            cyc;
    logic [BW-1:0] ub;
    logic          ins;
    logic          ovf;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [BW-1:0] acct;

  atm_transaction #(
    .balance_width (BW),
    .max_attempts  (3),
    .timeout_cycles(1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .card_in        (card_in),
    .psw_valid      (psw_valid),
    .wrong_psw      (wrong_psw),
    .balance        (balance),
    .op_valid       (op_valid),
    .op_code        (op_code),
    .amount         (amount),
    .updated_balance(updated_balance),
    .op_done        (op_done),
    .busy           (busy),
    .insufficient   (insufficient),
    .overflow_err   (overflow_err),
    .timeout        (timeout),
    .card_locked    (card_locked),
    .card_eject     (card_eject)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Account arithmetic: what a bank would write back for this request.
  function automatic exp_t model(input logic [1:0] code, input logic [BW-1:0] bal,
                                 input logic [BW-1:0] amt, input int at);
    exp_t e;
    e.cyc = at;
    e.ub  = bal;
    e.ins = 1'b0;
    e.ovf = 1'b0;
    if (code == 2'b01) begin
      if (longint'(bal) + longint'(amt) > longint'(BAL_MAX)) e.ovf = 1'b1;
      else e.ub = bal + amt;
    end else if (code == 2'b10) begin
      if (amt > bal) e.ins = 1'b1;
      else e.ub = bal - amt;
    end
    return e;
  endfunction

  // Monitor: every op_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && op_done) begin
      if (sbq.size() == 0) begin
        check("unexpected_op_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("op_done_cycle", cyc, e.cyc);
        check("updated_balance", updated_balance, e.ub);
        check("insufficient", insufficient, e.ins);
        check("overflow_err", overflow_err, e.ovf);
      end
    end else if (rst && (insufficient || overflow_err)) begin
      check("flag_outside_done", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_psw(input logic wrong);
    psw_valid = 1'b1;
    tick();
    psw_valid = 1'b0;
    wrong_psw = wrong;
    tick();
    wrong_psw = 1'b0;
  endtask

  task automatic login();
    card_in = 1'b1;
    tick();
    enter_psw(1'b0);
  endtask

  task automatic do_op(input logic [1:0] code, input logic [BW-1:0] amt);
    exp_t e;
    e = model(code, acct, amt, cyc + 2);
    balance  = acct;
    op_valid = 1'b1;
    op_code  = code;
    amount   = amt;
    sbq.push_back(e);
    tick();
    op_valid = 1'b0;
    op_code  = 2'($urandom);
    amount   = BW'($urandom);
    tick();
    tick();
    acct    = e.ub;
    balance = acct;
  endtask

  task automatic do_exit();
    op_valid = 1'b1;
    op_code  = 2'b11;
    tick();
    op_valid = 1'b0;
    tick();
    check("exit_eject", card_eject, 1);
    tick();
    check("exit_idle_busy", busy, 0);
    card_in = 1'b0;
    tick();
  endtask

  task automatic pick_amount(output logic [BW-1:0] amt);
    case ($urandom_range(0, 3))
      0: amt = acct;
      1: amt = (acct == BAL_MAX) ? acct : acct + 1'b1;
      2: amt = BW'($urandom_range(0, 255));
      default: amt = BW'($urandom);
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] amt;
    int early;

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {updated_balance, op_done, busy, insufficient, overflow_err,
                            timeout, card_locked, card_eject}, 0);
    balance = 20'd123;
    rst = 1'b1;
    tick();
    check("idle_tracks_balance", updated_balance, 123);
    check("idle_not_busy", busy, 0);

    // Directed balance operations
    acct = 20'd1000;
    login();
    check("menu_busy", busy, 1);
    do_op(2'b10, 20'd300);
    acct = 20'd1000;
    do_op(2'b10, 20'd1001);
    do_op(2'b10, 20'd1000);
    acct = BAL_MAX;
    do_op(2'b01, 20'd1);
    acct = 20'd10;
    do_op(2'b01, 20'd5);
    do_op(2'b00, BW'($urandom));
    do_exit();

    // Three wrong passwords lock the card
    card_in = 1'b1;
    tick();
    enter_psw(1'b1);
    check("retry_auth_busy", busy, 1);
    enter_psw(1'b1);
    enter_psw(1'b1);
    check("lock_pulse", card_locked, 1);
    check("lock_eject", card_eject, 1);
    tick();
    check("lock_idle", busy, 0);
    check("lock_pulse_one_cycle", {card_locked, card_eject}, 0);
    tick();
    tick();
    check("no_reentry_card_held", busy, 0);
    card_in = 1'b0;
    tick();

    // Two wrong then right reaches MENU
    card_in = 1'b1;
    tick();
    enter_psw(1'b1);
    enter_psw(1'b1);
    enter_psw(1'b0);
    check("recover_menu_busy", busy, 1);
    check("recover_no_lock", card_locked, 0);
    acct = 20'd77;
    do_op(2'b00, 20'd0);

    // MENU idle timeout
    early = 0;
    repeat (999) begin
      tick();
      if (timeout || card_eject || !busy) early++;
    end
    check("timeout_not_early", early, 0);
    tick();
    check("timeout_pulse", timeout, 1);
    check("timeout_eject", card_eject, 1);
    tick();
    check("timeout_idle", busy, 0);
    check("timeout_one_cycle", timeout, 0);
    card_in = 1'b0;
    tick();

    // Card pulled during EXEC
    acct = 20'd500;
    balance = acct;
    login();
    op_valid = 1'b1;
    op_code  = 2'b10;
    amount   = 20'd5;
    tick();
    op_valid = 1'b0;
    card_in  = 1'b0;
    tick();
    check("abort_idle", busy, 0);
    check("abort_no_done", op_done, 0);
    balance = 20'd4321;
    tick();
    check("abort_idle_tracks_balance", updated_balance, 4321);
    repeat (3) tick();

    // Reset during DONE
    acct = 20'd900;
    balance = acct;
    login();
    op_valid = 1'b1;
    op_code  = 2'b01;
    amount   = 20'd3;
    tick();
    op_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("reset_mid_done_outputs", {updated_balance, op_done, busy, insufficient,
                                     overflow_err, timeout, card_locked, card_eject}, 0);
    card_in = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("after_reset_idle", busy, 0);

    // Randomized sessions
    repeat (6) begin
      acct = BW'($urandom);
      if ($urandom_range(0, 3) == 0) acct = BAL_MAX - BW'($urandom_range(0, 3));
      balance = acct;
      login();
      repeat (8) begin
        if ($urandom_range(0, 4) == 0) acct = BW'($urandom);
        pick_amount(amt);
        do_op(2'($urandom_range(0, 2)), amt);
      end
      do_exit();
    end

    repeat (5) tick();
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_transaction.md
ATM_TRANSACTION -- requirements
Module: atm_transaction

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): balance_width, 20, balance/amount width; max_attempts, 3, wrong-password tries before lock; timeout_cycles, 1000, MENU idle limit in clocks.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: single clock, all state on rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- card_in, input, 1: card present.
- psw_valid, input, 1: a password was entered this cycle.
- wrong_psw, input, 1: password check result from card handling, valid the cycle after psw_valid.
- balance, input, balance_width: current account balance from card handling.
- op_valid, input, 1: operation request strobe.
- op_code, input, 2: 00 inquiry, 01 deposit, 10 withdraw, 11 exit.
- amount, input, balance_width: operation amount.
- updated_balance, output, balance_width: balance to write back.
- op_done, output, 1: one-cycle write-back strobe.
- busy, output, 1: high in any state except IDLE.
- insufficient, output, 1: withdraw rejected.
- overflow_err, output, 1: deposit rejected.
- timeout, output, 1: MENU idle timeout pulse.
- card_locked, output, 1: attempt-limit pulse.
- card_eject, output, 1: eject pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, AUTH, CHECK, MENU, EXEC, DONE and EJECT.
REQ-004 In IDLE with card_in=1, the FSM SHALL go to AUTH next cycle and clear the attempt counter.
REQ-005 In IDLE, updated_balance SHALL load balance every cycle, so a write-back while the card is out is a no-op.
REQ-006 In AUTH with psw_valid=1, the FSM SHALL go to CHECK; CHECK SHALL sample wrong_psw.
REQ-007 In CHECK with wrong_psw=0, the FSM SHALL go to MENU and clear attempts.
REQ-008 In CHECK with wrong_psw=1, the FSM SHALL increment attempts; at attempts==max_attempts it SHALL go to EJECT with card_locked pulsed for 1 cycle, else return to AUTH.
REQ-009 In MENU, the idle counter SHALL increment each cycle while op_valid=0 and clear on op_valid=1 or on MENU entry; at count==timeout_cycles-1 the FSM SHALL go to EJECT with timeout pulsed for 1 cycle.
REQ-010 In MENU with op_valid=1, op_code and amount SHALL be registered and the FSM SHALL go to EXEC; op_valid outside MENU SHALL be ignored.
REQ-011 EXEC SHALL take exactly 1 cycle and compute:
- inquiry: updated_balance=balance.
- deposit: if balance+amount carries beyond balance_width, updated_balance=balance and overflow_err=1; else updated_balance=balance+amount.
- withdraw: amount>balance gives updated_balance=balance and insufficient=1; amount==balance is legal and yields 0.
- exit: go to EJECT without op_done.
REQ-012 DONE SHALL assert op_done for exactly 1 cycle, hold updated_balance, and return to MENU.
REQ-013 Latency from op_valid sampled to op_done high SHALL be 2 clocks.
REQ-014 insufficient and overflow_err SHALL be high only during the DONE cycle.
REQ-015 EJECT SHALL assert card_eject for 1 cycle and go to IDLE.
REQ-016 card_eject SHALL NOT reassert until card_in has been low for at least one cycle; IDLE re-entry on a card still inserted waits for card_in=0 then 1.
REQ-017 card_in=0 in any non-IDLE state SHALL abort to IDLE next cycle without asserting op_done, and updated_balance SHALL keep its last committed value.
REQ-018 An abort in the same cycle as DONE SHALL still complete op_done.
REQ-019 busy SHALL be combinational from the state.

Reset
REQ-020 When rst=0, the block SHALL immediately (asynchronously) force state IDLE, attempts 0, idle counter 0, and all outputs 0 including updated_balance.
REQ-021 Reset asserted mid-operation SHALL discard any pending EXEC/DONE without asserting op_done.

Verification
REQ-022 A bench SHALL cover:
- Insert card, psw_valid with wrong_psw=0, then withdraw amount=300 with balance=1000 -> op_done 2 clocks after op_valid, updated_balance=700, insufficient=0.
- Withdraw 1001 with balance=1000 -> op_done=1, insufficient=1, updated_balance=1000; withdraw 1000 -> updated_balance=0.
- Deposit 1 with balance=2^20-1 -> overflow_err=1, updated_balance=1048575; deposit 5 with balance 10 -> 15.
- Three consecutive wrong_psw=1 -> card_locked and card_eject pulse, state IDLE; two wrong then correct -> MENU.
- No op_valid for timeout_cycles cycles in MENU -> timeout and card_eject pulse, no op_done.
- card_in dropped during EXEC, and rst pulsed during DONE -> no further op_done; all outputs 0 after reset.
